hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing unit for the five-stage MIPS core (IF, ID, EX, MEM, WB). It keeps its own shadow copy of the destination and write-enable information for the EX, MEM and WB stages. From those shadows and the decode-stage controller signals it drives the pipeline-register enables and flushes, detects load-use and JR hazards, and issues forwarding selects for the EX operands and for the JR target. It sits beside the decode controller and owns every stall and flush decision in the core.

## Interface
- `REG_AW`, default 5: register-number width.
- `CNT_W`, default 32: performance counter width; used only with `HAZARD_PERF_CNT_EN`.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ext_stall`  in  1  memory-busy freeze request.
- `id_valid`  in  1  the ID stage holds a real instruction.
- `id_rs`, `id_rt`  in  REG_AW  source registers of the ID instruction.
- `id_uses_rs`, `id_uses_rt`  in  1  the ID instruction reads that source.
- `id_dst`  in  REG_AW  final destination of the ID instruction, after RegDst/PctoReg muxing.
- `id_reg_write`, `id_mem_to_reg`  in  1  decode controller outputs.
- `id_jump`, `id_jr`  in  1  J/JAL, and JR, both resolved in ID.
- `ex_branch_taken`  in  1  the branch resolved in EX is taken.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1  register enables.
- `ifid_flush`, `idex_flush`  out  1  the target register loads a bubble on the next edge.
- `fwd_a`, `fwd_b`  out  2  EX rs/rt operand select: 00 register file, 01 MEM ALU result, 10 WB data.
- `fwd_jr`  out  2  JR target select, same encoding.
- `stall_cnt`, `flush_cnt`  out  CNT_W  only with `HAZARD_PERF_CNT_EN`.

## Operation
- The shadow stages EX, MEM and WB each hold: valid, dst, reg_write, mem_to_reg. The EX shadow also holds rs, rt, uses_rs and uses_rt.
- A shadow write is effective only if valid=1, reg_write=1 and dst≠0.
- Hazard conditions:
  - Load-use: the EX shadow is an effective load (mem_to_reg=1) and its dst equals a used ID source.
  - JR hazard: id_jr=1 and either the EX shadow effectively writes rs, or the MEM shadow is an effective load writing rs.
- Decisions, highest priority first:
  1. `ext_stall`=1: every enable is 0, both flushes are 0, and the shadows hold.
  2. `ex_branch_taken`=1: all enables are 1, `ifid_flush`=1 and `idex_flush`=1. This overrides any ID hazard.
  3. Load-use or JR hazard: `pc_en`=0 and `ifid_en`=0; `idex_flush`=1; all other enables are 1.
  4. `id_jump` or `id_jr` (no hazard): all enables are 1 and `ifid_flush`=1.
  5. Otherwise: all enables are 1 and both flushes are 0.
- All ID-derived conditions are qualified by `id_valid`.
- Shadow advance on an edge without `ext_stall`:
  - WB ← MEM.
  - MEM ← EX.
  - EX ← bubble (valid=0) if `idex_flush` is high, else the ID fields.
- `fwd_a` (`fwd_b` and `fwd_jr` follow the same rule with rt and ID rs):
  - 01 when the MEM shadow effectively writes the EX rs and is not a load.
  - else 10 when the WB shadow effectively writes it.
  - else 00.
  - MEM has priority over WB.
  - Register 0 never forwards.
- The forwarding outputs are combinational and stay valid during `ext_stall`.

## Timing
- All control outputs are combinational from inputs and shadows, with zero latency in the same cycle.
- A load-use hazard stalls exactly 1 cycle.
- A JR hazard stalls 1 cycle when caused by an EX ALU write or a MEM load, and 2 cycles when caused by an EX load.
- A taken branch costs 2 bubbles. J, JAL and an unstalled JR cost 1 bubble.
- Reset:
  - Asynchronous reset invalidates all shadows and clears the counters to 0.
  - While `rst_n`=0 the outputs are forced: all enables 0, `ifid_flush`=1, `idex_flush`=1, all forwarding selects 00.
  - The first edge after release behaves as case 5 (no hazard).
- Reset mid-stall: the stall is abandoned and the shadows are empty.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments in each case-3 cycle.
  - `flush_cnt` increments in each case-2 or case-4 cycle.
  - Both counters saturate at all-ones and hold during `ext_stall`.
- Undefined: both counter ports and their registers are absent.

## Test plan
- Load-use:
  - Stimulus: lw $8 in EX, ID add using rs=8.
  - Required: one cycle with `pc_en`=0, `ifid_en`=0, `idex_flush`=1.
  - Next cycle: the EX shadow is a bubble, `fwd_a`=10 once the lw reaches WB, and the pipeline resumes.
- Forwarding priority:
  - Stimulus: $5 written by both MEM (ALU op) and WB, EX reads rs=5; then EX reads $0 with MEM dst=0.
  - Required: `fwd_a`=01 for the first case, and 00 for the `$0` case.
- Branch overrides stall:
  - Stimulus: `ex_branch_taken`=1 together with a load-use in ID.
  - Required: `pc_en`=1, `ifid_flush`=1, `idex_flush`=1, no stall; `flush_cnt`+1 with the macro defined.
- JR after lw:
  - Stimulus: lw $31 in EX, `id_jr` with rs=31.
  - Required: 2 stall cycles, then `fwd_jr`=10 and `ifid_flush`=1.
- `ext_stall` and reset:
  - Stimulus: `ext_stall` held 3 cycles during a load-use.
  - Required: all enables 0 and shadows unchanged throughout; the hazard is resolved after release.
  - Then assert `rst_n`=0 asynchronously mid-cycle. Required: outputs immediately take their reset values and the counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Owns every stall, flush and forwarding decision of the five-stage MIPS pipeline.
// Keeps its own shadow copies of the EX, MEM and WB stages for this purpose.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_stall,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_jump,
    input  logic              id_jr,
    input  logic              ex_branch_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        fwd_jr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic              uses_rs;
        logic              uses_rt;
        logic [REG_AW-1:0] dst;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } ex_shadow_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] dst;
    } mem_shadow_t;

    // WB data is already selected by the datapath, so the load flag is not kept here.
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] dst;
    } wb_shadow_t;

    ex_shadow_t  ex_q,  ex_d;
    mem_shadow_t mem_q, mem_d;
    wb_shadow_t  wb_q,  wb_d;

    logic ex_wr, mem_wr, wb_wr, mem_alu_wr;
    logic load_use, jr_hazard;
    logic case_branch, case_hazard, case_jump;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              mem_ok,
        input logic [REG_AW-1:0] mem_dst,
        input logic              wb_ok,
        input logic [REG_AW-1:0] wb_dst
    );
        if (mem_ok && (mem_dst == src)) return 2'b01;
        if (wb_ok && (wb_dst == src))   return 2'b10;
        return 2'b00;
    endfunction

    // An effective write never targets $0, so $0 can never be forwarded.
    assign ex_wr      = ex_q.valid  & ex_q.reg_write  & (ex_q.dst  != '0);
    assign mem_wr     = mem_q.valid & mem_q.reg_write & (mem_q.dst != '0);
    assign wb_wr      = wb_q.valid  & wb_q.reg_write  & (wb_q.dst  != '0);
    assign mem_alu_wr = mem_wr & ~mem_q.mem_to_reg;

    assign load_use = id_valid & ex_wr & ex_q.mem_to_reg &
                      ((id_uses_rs & (id_rs == ex_q.dst)) | (id_uses_rt & (id_rt == ex_q.dst)));
    assign jr_hazard = id_valid & id_jr &
                       ((ex_wr & (id_rs == ex_q.dst)) |
                        (mem_wr & mem_q.mem_to_reg & (id_rs == mem_q.dst)));

    assign case_branch = ~ext_stall & ex_branch_taken;
    assign case_hazard = ~ext_stall & ~ex_branch_taken & (load_use | jr_hazard);
    assign case_jump   = ~ext_stall & ~ex_branch_taken & ~(load_use | jr_hazard) &
                         id_valid & (id_jump | id_jr);

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        fwd_jr     = 2'b00;

        if (ex_q.valid && ex_q.uses_rs)
            fwd_a = fwd_sel(ex_q.rs, mem_alu_wr, mem_q.dst, wb_wr, wb_q.dst);
        if (ex_q.valid && ex_q.uses_rt)
            fwd_b = fwd_sel(ex_q.rt, mem_alu_wr, mem_q.dst, wb_wr, wb_q.dst);
        if (id_valid)
            fwd_jr = fwd_sel(id_rs, mem_alu_wr, mem_q.dst, wb_wr, wb_q.dst);

        if (ext_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (case_branch) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (case_hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (case_jump) begin
            ifid_flush = 1'b1;
        end

        // Reset forces a fully frozen, fully flushed pipeline.
        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            fwd_a      = 2'b00;
            fwd_b      = 2'b00;
            fwd_jr     = 2'b00;
        end
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!ext_stall) begin
            wb_d.valid       = mem_q.valid;
            wb_d.reg_write   = mem_q.reg_write;
            wb_d.dst         = mem_q.dst;
            mem_d.valid      = ex_q.valid;
            mem_d.reg_write  = ex_q.reg_write;
            mem_d.mem_to_reg = ex_q.mem_to_reg;
            mem_d.dst        = ex_q.dst;
            if (case_branch || case_hazard) begin
                ex_d = '0;
            end else begin
                ex_d.valid      = id_valid;
                ex_d.reg_write  = id_reg_write;
                ex_d.mem_to_reg = id_mem_to_reg;
                ex_d.uses_rs    = id_uses_rs;
                ex_d.uses_rt    = id_uses_rt;
                ex_d.dst        = id_dst;
                ex_d.rs         = id_rs;
                ex_d.rt         = id_rt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Counters saturate at all-ones; case flags are already false during ext_stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (case_hazard && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if ((case_branch || case_jump) && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // CNT_W only sizes the counter ports, which are absent in this build.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
